alarm_controller: RTL and testbench

- Downstream consumer of the Digital_Clock time outputs (seconds, minutes, hours).
- Stores an alarm time and compares it against the running time every 1 Hz tick.
- Drives a buzzer through an IDLE/ARMED/RINGING/SNOOZE state machine with snooze-limit and ring-timeout handling.
- Shares the Clk_1sec domain with Digital_Clock, so all timers count in seconds.

---
 rtl/alarm_controller.sv | 173 +++++++++++++++++
 tb/tb_alarm_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// alarm_controller
//   Alarm unit that runs on the same 1 Hz clock as Digital_Clock. It holds an
//   alarm time, compares it with the running time on every tick, and drives a
//   buzzer through IDLE/ARMED/RINGING/SNOOZE with a snooze limit and a ring
//   timeout. Every output comes straight from a register.
//
//   Build option: ALARM_BLINK_EN -- when defined, the buzzer toggles every
//   cycle while RINGING (1,0,1,...). When undefined, it is steady high.
//
//   Ports
//     Clk_1sec                  1 Hz clock
//     reset                     synchronous, active low
//     seconds/minutes/hours     current time
//     alarm_enable              level; low forces IDLE
//     alarm_set                 strobe; loads set_hours/set_minutes if valid
//     snooze, stop              strobes
//     alarm_hours/minutes       stored alarm time
//     buzzer                    buzzer drive
//     state                     IDLE=0 ARMED=1 RINGING=2 SNOOZE=3
//     snooze_count              snoozes used in the current event
//     set_error                 one-cycle pulse when an alarm_set is rejected
//     missed                    one-cycle pulse when the ring timeout expires
module alarm_controller #(
  parameter int RING_TIMEOUT = 60,
  parameter int SNOOZE_SECS  = 300,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic       Clk_1sec,
  input  logic       reset,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  input  logic       alarm_enable,
  input  logic       alarm_set,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic       snooze,
  input  logic       stop,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic       buzzer,
  output logic [1:0] state,
  output logic [1:0] snooze_count,
  output logic       set_error,
  output logic       missed
);

  localparam int RW = (RING_TIMEOUT > 1) ? $clog2(RING_TIMEOUT) : 1;
  localparam int SW = (SNOOZE_SECS  > 1) ? $clog2(SNOOZE_SECS)  : 1;
  localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT - 1);
  localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SECS - 1);
  localparam logic [1:0]    SNZ_MAX   = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  state_t        st, st_n;
  logic [4:0]    ah_n;
  logic [5:0]    am_n;
  logic [1:0]    sc_n;
  logic [RW-1:0] ring_cnt, ring_n;
  logic [SW-1:0] snz_cnt, snz_n;
  logic          buz_n, se_n, miss_n;
  logic          match, set_ok;

  assign match  = (hours == alarm_hours) && (minutes == alarm_minutes) &&
                  (seconds == 6'd0);
  assign set_ok = (set_hours <= 5'd23) && (set_minutes <= 6'd59);
  assign state  = st;

  always_comb begin
    st_n   = st;
    ah_n   = alarm_hours;
    am_n   = alarm_minutes;
    sc_n   = snooze_count;
    ring_n = ring_cnt;
    snz_n  = snz_cnt;
    se_n   = 1'b0;
    miss_n = 1'b0;

    if (!alarm_enable) begin
      st_n = IDLE;
    end else if (alarm_set) begin
      // An accepted set re-arms from any state. A pending match is dropped
      // because the compare used the old alarm time.
      if (set_ok) begin
        ah_n = set_hours;
        am_n = set_minutes;
        st_n = ARMED;
      end else begin
        se_n = 1'b1;
      end
    end else begin
      case (st)
        IDLE:  st_n = ARMED;
        ARMED: begin
          if (match) begin
            st_n   = RINGING;
            ring_n = '0;
          end
        end
        RINGING: begin
          if (stop) begin
            st_n = ARMED;
          end else if (snooze && (snooze_count < SNZ_MAX)) begin
            st_n  = SNOOZE;
            sc_n  = snooze_count + 2'd1;
            snz_n = '0;
          end else if (ring_cnt == RING_LAST) begin
            st_n   = ARMED;
            miss_n = 1'b1;
          end else begin
            ring_n = ring_cnt + 1'b1;
          end
        end
        SNOOZE: begin
          if (stop) begin
            st_n = ARMED;
          end else if (snz_cnt == SNZ_LAST) begin
            st_n   = RINGING;
            ring_n = '0;
          end else begin
            snz_n = snz_cnt + 1'b1;
          end
        end
        default: st_n = IDLE;
      endcase
    end

    // Leaving the alarm event (to ARMED or IDLE) closes it out.
    if (st_n == ARMED || st_n == IDLE) begin
      sc_n   = '0;
      ring_n = '0;
      snz_n  = '0;
    end

`ifdef ALARM_BLINK_EN
    // The buzzer is 1 on the first ringing cycle and toggles after that.
    buz_n = (st_n == RINGING) && ((st != RINGING) || !buzzer);
`else
    buz_n = (st_n == RINGING);
`endif
  end

  always_ff @(posedge Clk_1sec) begin
    if (!reset) begin
      st            <= IDLE;
      alarm_hours   <= '0;
      alarm_minutes <= '0;
      snooze_count  <= '0;
      ring_cnt      <= '0;
      snz_cnt       <= '0;
      buzzer        <= 1'b0;
      set_error     <= 1'b0;
      missed        <= 1'b0;
    end else begin
      st            <= st_n;
      alarm_hours   <= ah_n;
      alarm_minutes <= am_n;
      snooze_count  <= sc_n;
      ring_cnt      <= ring_n;
      snz_cnt       <= snz_n;
      buzzer        <= buz_n;
      set_error     <= se_n;
      missed        <= miss_n;
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Scoreboarded bench for alarm_controller. Stimulus pushes the expected
// output values for upcoming cycles; a negedge monitor pops and compares them.
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       reset, alarm_enable, alarm_set, snooze, stop;
  logic [5:0] seconds, minutes, set_minutes;
  logic [4:0] hours, set_hours;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       buzzer, set_error, missed;
  logic [1:0] state, snooze_count;

  alarm_controller dut (
    .Clk_1sec(clk), .reset(reset), .seconds(seconds), .minutes(minutes),
    .hours(hours), .alarm_enable(alarm_enable), .alarm_set(alarm_set),
    .set_hours(set_hours), .set_minutes(set_minutes), .snooze(snooze),
    .stop(stop), .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
    .buzzer(buzzer), .state(state), .snooze_count(snooze_count),
    .set_error(set_error), .missed(missed)
  );

  always #5 clk = ~clk;

  typedef enum int {F_ST, F_BUZ, F_SC, F_SE, F_MISS, F_AH, F_AM} fld_t;
  typedef struct {
    string tag;
    int    cyc;
    fld_t  fld;
    int    val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
  endtask

  function automatic int obs(input fld_t f);
    case (f)
      F_ST:    return int'(state);
      F_BUZ:   return int'(buzzer);
      F_SC:    return int'(snooze_count);
      F_SE:    return int'(set_error);
      F_MISS:  return int'(missed);
      F_AH:    return int'(alarm_hours);
      default: return int'(alarm_minutes);
    endcase
  endfunction

  // Compare every entry due in the current cycle.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        chk(q[i].tag, obs(q[i].fld), q[i].val);
        q.delete(i);
      end
    end
  end

  // Expectation for the outputs after the next rising edge.
  task automatic expect_nx(input string tag, input fld_t f, input int v);
    exp_t e;
    e.tag = tag; e.cyc = cyc + 1; e.fld = f; e.val = v;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hours = 5'(h); minutes = 6'(m); seconds = 6'(s);
  endtask

  // Buzzer level expected on the k-th ringing cycle (k=0 on entry).
  function automatic int buz_at(input int k);
`ifdef ALARM_BLINK_EN
    return (k % 2 == 0) ? 1 : 0;
`else
    if (k >= 0) return 1;
    return 0;
`endif
  endfunction

  // Reach 07:30:00 from ARMED and check that ringing starts, then move off
  // the match second so ARMED does not retrigger.
  task automatic ring_now(input string tag);
    set_time(7, 30, 0);
    expect_nx({tag, "_st"}, F_ST, 2);
    expect_nx({tag, "_buz"}, F_BUZ, 1);
    tick();
    set_time(7, 30, 1);
  endtask

  initial begin
    reset = 1'b0; alarm_enable = 1'b0; alarm_set = 1'b0; snooze = 1'b0;
    stop = 1'b0; set_hours = '0; set_minutes = '0;
    set_time(1, 2, 5);
    #1;
    // Reset: every output cleared.
    for (int r = 0; r < 2; r++) begin
      expect_nx("rst_st", F_ST, 0);   expect_nx("rst_buz", F_BUZ, 0);
      expect_nx("rst_sc", F_SC, 0);   expect_nx("rst_se", F_SE, 0);
      expect_nx("rst_miss", F_MISS, 0);
      expect_nx("rst_ah", F_AH, 0);   expect_nx("rst_am", F_AM, 0);
      tick();
    end
    reset = 1'b1; alarm_enable = 1'b1;
    expect_nx("idle_to_armed", F_ST, 1);
    tick();

    // Valid set, then two rejected sets.
    alarm_set = 1'b1; set_hours = 5'd7; set_minutes = 6'd30;
    expect_nx("set_ah", F_AH, 7); expect_nx("set_am", F_AM, 30);
    expect_nx("set_se", F_SE, 0); expect_nx("set_st", F_ST, 1);
    tick();
    set_hours = 5'd24; set_minutes = 6'd10;
    expect_nx("bad_h_se", F_SE, 1); expect_nx("bad_h_ah", F_AH, 7);
    expect_nx("bad_h_am", F_AM, 30);
    tick();
    set_hours = 5'd5; set_minutes = 6'd60;
    expect_nx("bad_m_se", F_SE, 1); expect_nx("bad_m_ah", F_AH, 7);
    expect_nx("bad_m_am", F_AM, 30);
    tick();
    alarm_set = 1'b0;
    expect_nx("se_pulse", F_SE, 0);
    tick();

    // One second early: no ring.
    set_time(7, 29, 59);
    expect_nx("early_st", F_ST, 1); expect_nx("early_buz", F_BUZ, 0);
    tick();

    // Ring to timeout: buzzer covers RING_TIMEOUT cycles, then missed.
    ring_now("ring1");
    for (int k = 1; k < 60; k++) begin
      expect_nx("ring_st", F_ST, 2);
      expect_nx("ring_buz", F_BUZ, buz_at(k));
      expect_nx("ring_miss", F_MISS, 0);
      tick();
    end
    expect_nx("tmo_st", F_ST, 1); expect_nx("tmo_buz", F_BUZ, 0);
    expect_nx("tmo_miss", F_MISS, 1);
    tick();
    expect_nx("miss_pulse", F_MISS, 0);
    tick();

    // Snooze three times; each snooze lasts SNOOZE_SECS.
    ring_now("ring2");
    for (int n = 1; n <= 3; n++) begin
      snooze = 1'b1;
      expect_nx("snz_st", F_ST, 3); expect_nx("snz_buz", F_BUZ, 0);
      expect_nx("snz_sc", F_SC, n);
      tick();
      snooze = 1'b0;
      for (int k = 1; k < 300; k++) begin
        if (k == 299) expect_nx("snz_hold", F_ST, 3);
        tick();
      end
      expect_nx("resume_st", F_ST, 2); expect_nx("resume_buz", F_BUZ, 1);
      expect_nx("resume_sc", F_SC, n);
      tick();
    end
    // Fourth snooze is ignored; ringing continues.
    snooze = 1'b1;
    expect_nx("snz4_st", F_ST, 2); expect_nx("snz4_sc", F_SC, 3);
    expect_nx("snz4_buz", F_BUZ, buz_at(1));
    tick();
    // stop and snooze together: stop wins.
    stop = 1'b1;
    expect_nx("stopsnz_st", F_ST, 1); expect_nx("stopsnz_sc", F_SC, 0);
    expect_nx("stopsnz_buz", F_BUZ, 0);
    tick();
    stop = 1'b0; snooze = 1'b0;
    tick();

    // alarm_enable low during SNOOZE: IDLE, alarm time kept.
    ring_now("ring3");
    snooze = 1'b1;
    expect_nx("snz5_st", F_ST, 3);
    tick();
    snooze = 1'b0; alarm_enable = 1'b0;
    expect_nx("dis_st", F_ST, 0); expect_nx("dis_sc", F_SC, 0);
    expect_nx("dis_ah", F_AH, 7); expect_nx("dis_am", F_AM, 30);
    tick();
    alarm_enable = 1'b1;
    expect_nx("reen_st", F_ST, 1);
    tick();

    // alarm_set coincident with a match: new time loaded, no ring.
    set_time(7, 30, 0);
    alarm_set = 1'b1; set_hours = 5'd0; set_minutes = 6'd0;
    expect_nx("setmatch_st", F_ST, 1); expect_nx("setmatch_buz", F_BUZ, 0);
    expect_nx("setmatch_ah", F_AH, 0); expect_nx("setmatch_am", F_AM, 0);
    tick();
    alarm_set = 1'b0;

    // Midnight wrap: 00:00 alarm rings at 00:00:00.
    set_time(23, 59, 59);
    expect_nx("pre_mid_st", F_ST, 1);
    tick();
    set_time(0, 0, 0);
    expect_nx("mid_st", F_ST, 2); expect_nx("mid_buz", F_BUZ, 1);
    tick();
    set_time(0, 0, 1);
    // Reset mid-ring clears buzzer at that edge.
    reset = 1'b0;
    expect_nx("rst_ring_st", F_ST, 0); expect_nx("rst_ring_buz", F_BUZ, 0);
    tick();
    reset = 1'b1;
    tick();

    @(negedge clk);
    #1;
    chk("sb_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
